// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer
// Wraps 32-bit ap_vld/ap_ack stream words into 49-bit BFT packets aimed at a
// configured destination leaf/port. Credit-based flow control against the
// destination receive buffer; config and freespace-update control packets
// arrive from the BFT on din_leaf_bft2interface.
// Packet layout: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk_bft,
  input  logic                     reset_n,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     bft_ready,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     configured
);

  // Credit counter must represent 0..2^NUM_ADDR_BITS inclusive.
  localparam int CW        = NUM_ADDR_BITS + 1;
  localparam int CW1       = CW + 1;
  localparam int ADDR_LSB  = PAYLOAD_BITS;
  localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT = PACKET_BITS - 1;

  localparam logic [CW-1:0] MAX_CREDITS = CW'(1 << NUM_ADDR_BITS);
  localparam logic [CW1-1:0] MAX_SUM    = CW1'(1 << NUM_ADDR_BITS);
  localparam logic [CW1-1:0] UPD_SIZE   = CW1'(FREESPACE_UPDATE_SIZE);

  typedef enum logic {
    ST_CFG = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  logic [1:0]                rst_sync_reg;
  logic                      rst_int_n;

  state_t                    state_reg, state_next;

  logic                      ctrl_valid;
  logic [NUM_PORT_BITS-1:0]  ctrl_port;
  logic                      is_cfg;
  logic                      is_upd;
  logic                      beat;
  logic                      dout_valid;
  logic                      din_unused;

  logic [NUM_LEAF_BITS-1:0]  dest_leaf_reg, dest_leaf_next;
  logic [NUM_PORT_BITS-1:0]  dest_port_reg, dest_port_next;
  logic [NUM_ADDR_BITS-1:0]  wptr_reg, wptr_next;
  logic [CW-1:0]             credits_reg, credits_next;
  logic                      configured_reg, configured_next;
  logic [PACKET_BITS-1:0]    dout_reg, dout_next;
  logic [CW1-1:0]            credit_sum;

  // Reset asserts immediately, releases on a clock edge after two stages.
  always_ff @(posedge clk_bft or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_reg[1];

  // Control packet decode; only the port field selects the packet kind.
  assign ctrl_valid = din_leaf_bft2interface[VALID_BIT];
  assign ctrl_port  = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign is_cfg     = ctrl_valid && (ctrl_port == NUM_PORT_BITS'(0));
  assign is_upd     = ctrl_valid && (ctrl_port == NUM_PORT_BITS'(1));

  // Leaf/addr fields and high payload bits of control packets carry nothing here.
  assign din_unused = ^{din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                        din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS],
                        din_leaf_bft2interface[PAYLOAD_BITS-1:NUM_PORT_BITS+NUM_LEAF_BITS]};

  assign dout_valid = dout_reg[VALID_BIT];
  assign beat       = vld_user2interface && ack_interface2user;

  // FSM state register.
  always_ff @(posedge clk_bft or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg <= ST_CFG;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: the first config packet arms the block; only reset returns to CFG.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_CFG && is_cfg) begin
      state_next = ST_RUN;
    end
  end

  // FSM output: ack never looks at vld, and never overwrites an unconsumed packet.
  always_comb begin
    ack_interface2user = 1'b0;
    if (state_reg == ST_RUN) begin
      ack_interface2user = (credits_reg != '0) && (!dout_valid || bft_ready);
    end
  end

  // Datapath next values: config beats update, update beats a plain beat.
  always_comb begin
    dest_leaf_next  = dest_leaf_reg;
    dest_port_next  = dest_port_reg;
    wptr_next       = wptr_reg;
    credits_next    = credits_reg;
    configured_next = configured_reg;
    dout_next       = dout_reg;
    credit_sum      = {1'b0, credits_reg} + UPD_SIZE - CW1'(beat);

    // Outgoing packet uses the destination/wptr held before this edge.
    if (beat) begin
      dout_next = {1'b1, dest_leaf_reg, dest_port_reg, wptr_reg, din_leaf_user2interface};
    end else if (dout_valid && bft_ready) begin
      dout_next = '0;
    end

    if (beat) begin
      wptr_next = wptr_reg + NUM_ADDR_BITS'(1);
    end

    if (is_cfg) begin
      dest_leaf_next  = din_leaf_bft2interface[NUM_PORT_BITS +: NUM_LEAF_BITS];
      dest_port_next  = din_leaf_bft2interface[NUM_PORT_BITS-1:0];
      credits_next    = MAX_CREDITS;
      wptr_next       = '0;
      configured_next = 1'b1;
    end else if (is_upd) begin
      credits_next = (credit_sum > MAX_SUM) ? MAX_CREDITS : credit_sum[CW-1:0];
    end else if (beat) begin
      credits_next = credits_reg - CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_bft or negedge rst_int_n) begin
    if (!rst_int_n) begin
      dest_leaf_reg  <= '0;
      dest_port_reg  <= '0;
      wptr_reg       <= '0;
      credits_reg    <= '0;
      configured_reg <= 1'b0;
      dout_reg       <= '0;
    end else begin
      dest_leaf_reg  <= dest_leaf_next;
      dest_port_reg  <= dest_port_next;
      wptr_reg       <= wptr_next;
      credits_reg    <= credits_next;
      configured_reg <= configured_next;
      dout_reg       <= dout_next;
    end
  end

  assign dout_leaf_interface2bft = dout_reg;
  assign credits                 = credits_reg;
  assign configured              = configured_reg;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Randomized + directed bench for leaf_stream_packetizer. A reference model
// predicts ack/credits per cycle and pushes expected packets into a queue;
// a monitor pops them when the BFT consumes dout.
module tb_leaf_stream_packetizer;

  logic        clk_bft = 1'b0;
  logic        reset_n = 1'b0;
  logic [48:0] din_leaf_bft2interface = '0;
  logic [31:0] din_leaf_user2interface = '0;
  logic        vld_user2interface = 1'b0;
  logic        ack_interface2user;
  logic [48:0] dout_leaf_interface2bft;
  logic        bft_ready = 1'b0;
  logic [7:0]  credits;
  logic        configured;

  leaf_stream_packetizer dut (
    .clk_bft                 (clk_bft),
    .reset_n                 (reset_n),
    .din_leaf_bft2interface  (din_leaf_bft2interface),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .bft_ready               (bft_ready),
    .credits                 (credits),
    .configured              (configured)
  );

  always #5 clk_bft = ~clk_bft;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_credits;
  int          m_wptr;
  bit          m_running;
  bit          m_configured;
  bit          m_dvalid;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  logic [48:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_pkt(input string name, input logic [48:0] act, input logic [48:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [48:0] mk_ctrl(input logic [3:0] port, input logic [31:0] pay);
    mk_ctrl = {1'b1, 5'd0, port, 7'd0, pay};
  endfunction

  function automatic void model_reset();
    m_credits = 0; m_wptr = 0; m_running = 0; m_configured = 0; m_dvalid = 0;
    m_leaf = '0; m_port = '0;
    exp_q.delete();
  endfunction

  // One clock cycle: drive, compare visible state against the model, advance the model.
  task automatic cycle(input bit v, input logic [31:0] d, input logic [48:0] c, input bit r);
    bit exp_ack, beat, is_c, is_u;
    @(posedge clk_bft);
    #1;
    vld_user2interface      = v;
    din_leaf_user2interface = d;
    din_leaf_bft2interface  = c;
    bft_ready               = r;
    #3;
    exp_ack = m_running && (m_credits != 0) && (!m_dvalid || r);
    check("ack", ack_interface2user, exp_ack);
    check("credits", credits, m_credits);
    check("configured", configured, m_configured);
    check("dout_valid", dout_leaf_interface2bft[48], m_dvalid);
    beat = v && exp_ack;
    is_c = c[48] && (c[42:39] == 4'd0);
    is_u = c[48] && (c[42:39] == 4'd1);
    if (beat) begin
      exp_q.push_back({1'b1, m_leaf, m_port, 7'(m_wptr), d});
      m_wptr = (m_wptr + 1) % 128;
      m_credits = m_credits - 1;
      m_dvalid = 1;
    end else if (m_dvalid && r) begin
      m_dvalid = 0;
    end
    if (is_c) begin
      m_leaf = c[8:4]; m_port = c[3:0];
      m_credits = 128; m_wptr = 0; m_configured = 1; m_running = 1;
    end else if (is_u) begin
      m_credits = (m_credits + 64 > 128) ? 128 : m_credits + 64;
    end
    $display("cyc vld=%0b data=%h ctrl=%h rdy=%0b ack=%0b credits=%0d", v, d, c, r, exp_ack, m_credits);
  endtask

  task automatic do_reset();
    @(posedge clk_bft);
    #1;
    reset_n = 1'b0;
    vld_user2interface = 1'b1;
    din_leaf_bft2interface = '0;
    #1;
    check("rst_dout", int'(dout_leaf_interface2bft != '0), 0);
    check("rst_ack", ack_interface2user, 0);
    model_reset();
    repeat (3) @(posedge clk_bft);
    #1;
    reset_n = 1'b1;
    vld_user2interface = 1'b0;
    repeat (3) cycle(0, '0, '0, 1);
  endtask

  // Monitor: pop and compare whenever the BFT consumes a valid packet.
  bit          hold = 0;
  logic [48:0] hold_pkt;
  always @(negedge clk_bft) begin
    if (!reset_n) begin
      hold = 0;
    end else begin
      if (hold) check_pkt("hold_stable", dout_leaf_interface2bft, hold_pkt);
      if (dout_leaf_interface2bft[48]) begin
        if (bft_ready) begin
          if (exp_q.size() == 0) begin
            check_pkt("pkt_unexpected", dout_leaf_interface2bft, '0);
          end else begin
            check_pkt("pkt", dout_leaf_interface2bft, exp_q.pop_front());
          end
          hold = 0;
        end else begin
          hold = 1;
          hold_pkt = dout_leaf_interface2bft;
        end
      end else begin
        hold = 0;
      end
    end
  end

  initial begin
    int r2;
    logic [31:0] rnd;
    model_reset();
    do_reset();

    // Unconfigured: vld held high, ack must stay low.
    repeat (4) cycle(1, 32'h1234, '0, 1);
    cycle(0, '0, mk_ctrl(4'd0, 32'h153), 1);
    cycle(0, '0, '0, 1);
    check("cfg_credits", credits, 128);
    check("cfg_ack", ack_interface2user, 1);

    // Streaming three words.
    cycle(1, 32'hA, '0, 1);
    cycle(1, 32'hB, '0, 1);
    cycle(1, 32'hC, '0, 1);
    cycle(0, '0, '0, 1);
    check("stream_credits", credits, 125);

    // Backpressure.
    cycle(1, 32'hD, '0, 0);
    repeat (3) cycle(1, 32'hE, '0, 0);
    cycle(1, 32'hF, '0, 1);
    cycle(0, '0, '0, 1);

    // Exhaust credits.
    for (int i = 0; i < 300 && m_credits > 0; i++) cycle(1, $urandom, '0, 1);
    cycle(1, 32'h55, '0, 1);
    check("exhaust_credits", credits, 0);
    check("exhaust_ack", ack_interface2user, 0);
    cycle(0, '0, mk_ctrl(4'd1, '0), 1);
    cycle(0, '0, '0, 1);
    check("upd1", credits, 64);
    cycle(1, 32'h129, '0, 1);
    cycle(0, '0, mk_ctrl(4'd1, '0), 1);
    cycle(0, '0, mk_ctrl(4'd1, '0), 1);
    cycle(0, '0, '0, 1);
    check("upd_sat", credits, 128);

    // Update coinciding with a beat at credits=10.
    for (int i = 0; i < 300 && m_credits > 10; i++) cycle(1, $urandom, '0, 1);
    cycle(1, 32'h77, mk_ctrl(4'd1, '0), 1);
    cycle(0, '0, '0, 1);
    check("upd_beat", credits, 73);

    // Config coinciding with a beat.
    cycle(1, 32'hDEAD, mk_ctrl(4'd0, 32'h2A7), 1);
    cycle(0, '0, '0, 1);
    check("cfg_beat_credits", credits, 128);
    cycle(1, 32'hBEEF, '0, 1);
    cycle(0, '0, '0, 1);

    // Mid-stream reset with a held packet.
    cycle(1, 32'h99, '0, 0);
    cycle(0, '0, '0, 0);
    do_reset();
    repeat (3) cycle(1, 32'h1, '0, 1);
    cycle(0, '0, mk_ctrl(4'd0, 32'h0E2), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r2 = $urandom_range(0, 199);
      rnd = $urandom;
      if (r2 < 2)        cycle(($urandom % 4) != 0, $urandom, mk_ctrl(4'd1, rnd), ($urandom % 4) != 0);
      else if (r2 < 3)   cycle(($urandom % 4) != 0, $urandom, mk_ctrl(4'd0, rnd), ($urandom % 4) != 0);
      else if (r2 < 8)   cycle(($urandom % 4) != 0, $urandom, mk_ctrl(4'($urandom_range(2, 15)), rnd), ($urandom % 4) != 0);
      else if (r2 < 12)  cycle(($urandom % 4) != 0, $urandom, {1'b0, 48'($urandom)}, ($urandom % 4) != 0);
      else if (r2 < 14)  cycle(($urandom % 4) != 0, $urandom, {1'b1, 5'($urandom), 4'd1, 39'($urandom)}, ($urandom % 4) != 0);
      else               cycle(($urandom % 4) != 0, $urandom, '0, ($urandom % 4) != 0);
    end

    repeat (3) cycle(0, '0, '0, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
